ws2812_bit_enc: RTL
===================

// Module: ws2812_bit_enc
// PURPOSE
//  Serializes a byte stream into the single-wire WS2812 (NeoPixel) NRZ waveform, MSB first.
//  Sits downstream of the reset synchronizer: its rst_n_i is the synchronized reset.
//  Takes bytes from the frame/pixel buffer over a valid/ready handshake.
//  Drives the LED data pin and, optionally, the frame latch (reset-code) low period.
// PARAMETERS
//  T0H    20     cycles bit_o high for a '0' bit (0.40 us @ 50 MHz)
//  T0L    42     cycles bit_o low for a '0' bit (0.84 us)
//  T1H    40     cycles bit_o high for a '1' bit (0.80 us)
//  T1L    22     cycles bit_o low for a '1' bit (0.44 us)
//  T_RST  15000  cycles of latch low after the last byte of a frame (300 us)
//  CNT_W  16     phase counter width; every timing parameter must be in 1..2^CNT_W-1
// PORTS
//  clk_i    in   1  system clock
//  rst_n_i  in   1  reset, synchronous, active-low
//  data_i   in   8  byte to transmit, MSB first
//  valid_i  in   1  data_i/last_i valid
//  last_i   in   1  data_i is the final byte of a frame
//  ready_o  out  1  encoder accepts a byte this cycle
//  bit_o    out  1  WS2812 data line, registered
//  busy_o   out  1  FSM not in IDLE
//  done_o   out  1  one-cycle pulse at frame completion
// BEHAVIOUR
//  Reset: one clock and one reset; reset is synchronous and active-low.
//   While rst_n_i==0: state=IDLE, bit_o=0, done_o=0, busy_o=0, ready_o=0, shift reg/counters cleared.
//  FSM states: IDLE, HIGH, LOW, LATCH.
//  Handshake: a byte transfers when valid_i && ready_o at a rising edge; ready_o never depends on valid_i.
//   ready_o=1 in IDLE, and on the final LOW cycle of bit 0 of a byte captured with last=0.
//  Timing:
//   - IDLE: accept -> load shift reg and last flag, bit index=7, state=HIGH; bit_o=1 on the next cycle.
//   - HIGH: bit_o=1 for exactly T1H/T0H cycles for the current bit, then LOW.
//   - LOW: bit_o=0 for exactly T1L/T0L cycles.
//   - End of LOW with bit index>0: decrement index, go to HIGH; no idle cycle between bits.
//   - End of LOW of bit 0 with a byte accepted that cycle: HIGH of the new MSB; zero gap.
//   - End of LOW of bit 0, last=0, no byte accepted: go to IDLE with bit_o=0.
//     Downstream pixels tolerate the gap while it stays below the latch time.
//   - End of LOW of bit 0, last=1: see CONFIGURATION.
//  Phase counter loads (Txx-1) on phase entry and counts down to 0; phase ends on the cycle it reads 0.
//  Bit period is TxH+TxL exactly; 8 bits = 496 cycles at defaults.
//  busy_o = (state != IDLE), registered with state.
//  done_o is high for exactly one cycle per frame, coincident with entering IDLE.
//  data_i and last_i are ignored when no handshake occurs; valid_i may drop at any time.
//  Reset mid-operation: at the reset edge bit_o goes to 0; the in-flight byte is discarded; no done_o.
// CONFIGURATION
//  WS2812_LATCH_EN defined:
//   - After the final LOW of a last=1 byte, enter LATCH: bit_o=0, ready_o=0 for T_RST cycles.
//   - Then done_o pulses and the FSM returns to IDLE.
//  WS2812_LATCH_EN undefined:
//   - LATCH state and T_RST logic are absent.
//   - After the final LOW of a last=1 byte, go straight to IDLE with done_o=1 for that cycle.
//   - Upstream is responsible for the latch gap.
// TESTING
//  1 Hold rst_n_i=0 for 3 cycles with valid_i=1 -> bit_o=0, ready_o=0, busy_o=0, done_o=0 throughout.
//  2 Send 0xA5 with last=1 (LATCH_EN, defaults) -> bit_o pattern, cycles high/low per bit:
//    40/22, 20/42, 40/22, 20/42, 20/42, 40/22, 20/42, 40/22 (496 cycles);
//    then 15000 low; then done_o=1 for 1 cycle; busy_o falls with it.
//  3 Hold valid_i=1 for 3 bytes 0xFF,0x00,0x81 (last on 3rd)
//    -> 1488 contiguous bit cycles, no idle gap;
//    -> ready_o high exactly once per byte boundary; one done_o.
//  4 Send 0x80 with last=0, then valid_i=0 for 10 cycles, then 0x01 with last=1
//    -> IDLE reached after 496 cycles with bit_o=0, busy_o=0, no done_o;
//    -> second byte starts 1 cycle after its handshake.
//  5 Assert rst_n_i=0 at cycle 30 of the HIGH phase of bit 6
//    -> bit_o=0 at the next edge, IDLE, no done_o;
//    -> a new byte after release encodes from its MSB.
//  6 WS2812_LATCH_EN undefined, send 0x00 with last=1
//    -> done_o=1 on cycle 497 after the handshake, no latch period;
//    -> ready_o=1 that same cycle.

Source files
------------

// File: rtl/ws2812_bit_enc.sv
`timescale 1ns/1ps
// ws2812_bit_enc
// Serialises a byte stream into the single-wire WS2812 (NeoPixel) NRZ
// waveform, MSB first. Bytes arrive over a valid/ready handshake. Each bit
// is a high phase followed by a low phase, and the phase lengths depend on
// the bit value. Reset is synchronous and active-low. It comes from the
// upstream reset synchroniser.
//
// Optional feature macro: WS2812_LATCH_EN
//   defined   : after the last byte of a frame the line is held low for
//               T_RST cycles (LATCH state), then done_o pulses.
//   undefined : the LATCH state and T_RST are not built; done_o pulses as
//               soon as the last bit's low phase ends, and upstream owns
//               the latch gap.
module ws2812_bit_enc #(
    parameter int T0H   = 20,
    parameter int T0L   = 42,
    parameter int T1H   = 40,
    parameter int T1L   = 22,
`ifdef WS2812_LATCH_EN
    parameter int T_RST = 15000,
`endif
    parameter int CNT_W = 16
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    input  logic       last_i,
    output logic       ready_o,
    output logic       bit_o,
    output logic       busy_o,
    output logic       done_o
);

    // On entry to a phase, the phase counter is loaded with (length - 1).
    // The phase ends on the cycle the counter reads zero.
    localparam logic [CNT_W-1:0] T0H_M1  = CNT_W'(T0H - 1);
    localparam logic [CNT_W-1:0] T0L_M1  = CNT_W'(T0L - 1);
    localparam logic [CNT_W-1:0] T1H_M1  = CNT_W'(T1H - 1);
    localparam logic [CNT_W-1:0] T1L_M1  = CNT_W'(T1L - 1);
`ifdef WS2812_LATCH_EN
    localparam logic [CNT_W-1:0] T_RST_M1 = CNT_W'(T_RST - 1);
`endif
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
`ifdef WS2812_LATCH_EN
        ,
        LATCH
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [2:0]       idx_q, idx_d;
    logic             last_q, last_d;
    logic             done_d;
    logic             ready_c;
    logic             load;

    // ready_o does not depend on valid_i. It is also forced low while reset
    // is held, so no byte can be accepted before reset is released.
    assign ready_o = rst_n_i & ready_c;

    // Next-state logic, phase timing, and byte acceptance for the encoder.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        last_d  = last_q;
        done_d  = 1'b0;
        ready_c = 1'b0;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                load    = valid_i;
            end

            HIGH: begin
                if (cnt_q == '0) begin
                    state_d = LOW;
                    cnt_d   = shreg_q[7] ? T1L_M1 : T0L_M1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            LOW: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (idx_q != 3'd0) begin
                    // Move to the next bit with no idle cycle in between.
                    idx_d   = idx_q - 3'd1;
                    shreg_d = {shreg_q[6:0], 1'b0};
                    state_d = HIGH;
                    cnt_d   = shreg_q[6] ? T1H_M1 : T0H_M1;
                end else if (last_q) begin
`ifdef WS2812_LATCH_EN
                    state_d = LATCH;
                    cnt_d   = T_RST_M1;
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end else begin
                    // The last low cycle of a mid-frame byte can accept the
                    // next byte, so the bit stream continues without a gap.
                    ready_c = 1'b1;
                    if (valid_i) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

`ifdef WS2812_LATCH_EN
            LATCH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            shreg_d = data_i;
            last_d  = last_i;
            idx_d   = 3'd7;
            state_d = HIGH;
            cnt_d   = data_i[7] ? T1H_M1 : T0H_M1;
        end
    end

    // State, datapath, and registered outputs. In reset these are forced to
    // a quiet line, and any byte in flight is dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            bit_o   <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            bit_o   <= (state_d == HIGH);
            busy_o  <= (state_d != IDLE);
            done_o  <= done_d;
        end
    end

endmodule
